rf_mp: RTL and testbench
========================

Name: rf_mp

Overview:
- Parametrised successor of the core integer register file: configurable data width, register count and number of read ports.
- Adds asynchronous reset, same-cycle write-to-read bypass and a per-register pending scoreboard for long-latency writebacks (load, CSR).
- Sits between decode (operand fetch, driven in the fetch-operand state) and writeback (driven in the writeback state).
- Read values are registered; the hazard flag is produced alongside each value.

Parameters:
- XLEN, 32, data width of every register and data port.
- NREGS, 32, number of architectural registers; power of two, at least 2; register 0 reads as zero.
- NRP, 2, number of read ports (1..4).
- AW, log2(NREGS), register address width; derived, not overridden.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_stb  in  1  operand capture strobe (core asserts in fetch-operand state).
- rs_en  in  NRP  per-port read enable; bit p is port p.
- rs_addr  in  NRP*AW  per-port read address; port p occupies bits [p*AW +: AW].
- rs_val  out  NRP*XLEN  registered read data; port p occupies bits [p*XLEN +: XLEN].
- rs_busy  out  NRP  registered hazard flag: captured register still pending.
- wb_en  in  1  writeback strobe (core asserts in writeback state).
- wb_addr  in  AW  writeback destination.
- wb_sel  in  2  source select: 0 ALU, 1 load, 2 CSR, 3 reserved (treated as ALU).
- alu_result  in  XLEN  ALU writeback data.
- load_result  in  XLEN  load writeback data.
- csr_val  in  XLEN  CSR writeback data.
- sb_set  in  1  mark sb_addr pending (issue of a load or CSR op).
- sb_addr  in  AW  register to mark pending.
- pending  out  NREGS  live scoreboard bit vector (debug/stall logic).

Behaviour:
- Reset (rst_n low, asynchronous): all registers clear to 0; rs_val clears to 0; rs_busy clears to 0; pending clears to 0. Reset can land mid-operation; the first edge after release behaves as a normal cycle.
- Write: on an edge with wb_en=1 and wb_addr!=0, register[wb_addr] is loaded from the wb_sel-selected source. If wb_addr=0 the write is dropped and no state changes.
- Register 0: always reads 0, is never marked pending, and its rs_busy is always 0.
- Read: on an edge with rd_stb=1, for each port p:
  - rs_en[p]=1: rs_val[p] is loaded with register[rs_addr[p]]. Latency is 1 cycle; data is valid the cycle after rd_stb.
  - rs_en[p]=0: rs_val[p] is loaded with 0 and rs_busy[p] with 0.
- Read hold: with rd_stb=0, rs_val and rs_busy hold their values.
- Bypass: if rd_stb and wb_en coincide and rs_addr[p]==wb_addr!=0, rs_val[p] captures the new writeback data, not the stale array contents. This holds on every port independently, including when several ports hit the same address.
- Scoreboard:
  - sb_set with sb_addr!=0 sets pending[sb_addr] on the edge.
  - wb_en with wb_addr!=0 clears pending[wb_addr] on the edge.
  - Set and clear of the same address on the same edge: set wins, since a new issue supersedes the retiring write. Set and clear of different addresses both take effect.
- rs_busy: on a capture edge, rs_busy[p] = pending[rs_addr[p]] AND NOT (wb_en AND wb_addr==rs_addr[p]). A retiring write bypasses and clears the hazard in the same cycle. An sb_set on the same edge does not affect that capture; the set is visible from the next capture.
- Consumers: decode stalls and re-strobes rd_stb while any enabled rs_busy bit is 1. The block itself never stalls.
- Simultaneous rd_stb, wb_en and sb_set are all legal in one cycle.
- No simulation display or dump statements in synthesisable code.

Decomposition:
- Shared package core_pkg holds:
  - the wb_sel encodings (WB_ALU=0, WB_LOAD=1, WB_CSR=2);
  - the core state encodings (fetch-operand=2, writeback=4);
  - default XLEN.
- One sub-module, rf_scoreboard: NREGS-bit pending vector with the set/clear/priority rules and the per-port busy lookup.
- Read ports, bypass and the storage array stay in rf_mp as generate loops over NRP.

Test Plan:
- Reset: write 0xDEADBEEF to x5, pulse rst_n low between edges -> x5 reads 0x00000000, all pending bits 0, rs_val 0, without waiting for a clock edge.
- Basic write/read: wb_sel=0, alu_result=0x12345678 to x3; next cycle rd_stb with port0=x3, port1=x0 -> rs_val port0=0x12345678, port1=0, both rs_busy 0.
- Source select and x0 drop:
  - wb_sel=1, load_result=0xA5A5A5A5 to x7 -> x7 reads 0xA5A5A5A5;
  - wb_sel=2, csr_val=0x00000C00 to x8 -> x8 reads 0x00000C00;
  - write 0xFFFFFFFF to x0 -> x0 still reads 0.
- Bypass: x9 holds 0x11111111; same edge wb x9=0x22222222 and rd_stb with both ports reading x9 -> both ports show 0x22222222.
- Scoreboard:
  - sb_set x10, then rd_stb reading x10 -> rs_busy=1;
  - wb x10=0x55 on the same edge as a re-strobe -> rs_val=0x55, rs_busy=0, pending[10]=0;
  - sb_set and wb of x11 on the same edge -> pending[11]=1.
- Parametrised build: NRP=3, NREGS=16, XLEN=64, all three ports read distinct registers x1, x2, x15 written with 64-bit patterns -> correct per-port slicing, no aliasing between ports.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: writeback source encodings, core state encodings
// and the default datapath width.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_CSR  = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH_OP  = 3'd2,
    ST_WRITEBACK = 3'd4
  } core_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-writeback scoreboard: one bit per register, set on issue of a
// long-latency op and cleared when its writeback retires.
module rf_scoreboard
  import core_pkg::*;
#(
  parameter int  NREGS = 32,
  parameter int  NRP   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic              clr_i,
  input  logic [AW-1:0]     clr_addr_i,
  input  logic [NRP*AW-1:0] look_addr_i,
  output logic [NREGS-1:0]  pending_o,
  output logic [NRP-1:0]    busy_o
);

  logic [NREGS-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_i && clr_addr_i != '0) pending_d[clr_addr_i] = 1'b0;
    // NOTE: the set is applied after the clear so a new issue wins over a
    // retiring write to the same register; register 0 is never marked.
    if (set_i && set_addr_i != '0) pending_d[set_addr_i] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments only; the next-state
  // logic above is combinational and uses blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // A retiring writeback to the looked-up register clears the hazard at once.
  for (genvar p = 0; p < NRP; p++) begin : g_busy
    logic [AW-1:0] addr;
    assign addr      = look_addr_i[p*AW +: AW];
    assign busy_o[p] = pending_q[addr] & ~(clr_i && clr_addr_i == addr);
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/rf_mp.sv
// Multi-port integer register file with registered reads, write-to-read
// bypass and a pending scoreboard for long-latency writebacks.
module rf_mp
  import core_pkg::*;
#(
  parameter int  XLEN  = XLEN_DEFAULT,
  parameter int  NREGS = 32,
  parameter int  NRP   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_stb,
  input  logic [NRP-1:0]      rs_en,
  input  logic [NRP*AW-1:0]   rs_addr,
  output logic [NRP*XLEN-1:0] rs_val,
  output logic [NRP-1:0]      rs_busy,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [1:0]          wb_sel,
  input  logic [XLEN-1:0]     alu_result,
  input  logic [XLEN-1:0]     load_result,
  input  logic [XLEN-1:0]     csr_val,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic [NREGS-1:0]    pending
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] wb_data;
  logic            wb_live;
  logic [NRP-1:0]  look_busy;

  // Reserved encoding 3 falls through to the ALU source.
  always_comb begin
    wb_data = alu_result;
    case (wb_sel_e'(wb_sel))
      WB_LOAD: wb_data = load_result;
      WB_CSR:  wb_data = csr_val;
      default: wb_data = alu_result;
    endcase
  end

  assign wb_live = wb_en && (wb_addr != '0);

  // NOTE: the array is reset explicitly because the register file must read
  // zero after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (wb_live) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRP   (NRP)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_i       (sb_set),
    .set_addr_i  (sb_addr),
    .clr_i       (wb_en),
    .clr_addr_i  (wb_addr),
    .look_addr_i (rs_addr),
    .pending_o   (pending),
    .busy_o      (look_busy)
  );

  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val_d, val_q;
    logic            busy_d, busy_q;

    assign addr = rs_addr[p*AW +: AW];

    // NOTE: every combinational output gets a default first so no latch forms.
    always_comb begin
      val_d  = '0;
      busy_d = 1'b0;
      if (rs_en[p]) begin
        busy_d = look_busy[p];
        if (wb_live && wb_addr == addr) val_d = wb_data;
        else if (addr != '0)            val_d = regs_q[addr];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_q  <= '0;
        busy_q <= 1'b0;
      end else if (rd_stb) begin
        val_q  <= val_d;
        busy_q <= busy_d;
      end
    end

    assign rs_val[p*XLEN +: XLEN] = val_q;
    assign rs_busy[p]             = busy_q;
  end

endmodule

// File: tb/tb_rf_mp.sv
// Self-checking bench for rf_mp: directed scenarios plus random traffic
// against a sequential register-file model; second instance at 64b/16r/3p.
module tb_rf_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: XLEN=32, NREGS=32, NRP=2
  logic        rd_stb;
  logic [1:0]  rs_en;
  logic [9:0]  rs_addr;
  logic [63:0] rs_val;
  logic [1:0]  rs_busy;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [1:0]  wb_sel;
  logic [31:0] alu_result, load_result, csr_val;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [31:0] pending;

  rf_mp dut (
    .clk(clk), .rst_n(rst_n), .rd_stb(rd_stb), .rs_en(rs_en), .rs_addr(rs_addr),
    .rs_val(rs_val), .rs_busy(rs_busy), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_sel(wb_sel), .alu_result(alu_result), .load_result(load_result),
    .csr_val(csr_val), .sb_set(sb_set), .sb_addr(sb_addr), .pending(pending)
  );

  // Parametrised instance: XLEN=64, NREGS=16, NRP=3
  logic         d2_rd_stb;
  logic [2:0]   d2_rs_en;
  logic [11:0]  d2_rs_addr;
  logic [191:0] d2_rs_val;
  logic [2:0]   d2_rs_busy;
  logic         d2_wb_en;
  logic [3:0]   d2_wb_addr;
  logic [1:0]   d2_wb_sel;
  logic [63:0]  d2_alu, d2_load, d2_csr;
  logic         d2_sb_set;
  logic [3:0]   d2_sb_addr;
  logic [15:0]  d2_pending;

  rf_mp #(.XLEN(64), .NREGS(16), .NRP(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .rd_stb(d2_rd_stb), .rs_en(d2_rs_en),
    .rs_addr(d2_rs_addr), .rs_val(d2_rs_val), .rs_busy(d2_rs_busy),
    .wb_en(d2_wb_en), .wb_addr(d2_wb_addr), .wb_sel(d2_wb_sel),
    .alu_result(d2_alu), .load_result(d2_load), .csr_val(d2_csr),
    .sb_set(d2_sb_set), .sb_addr(d2_sb_addr), .pending(d2_pending)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers, pending set, captured outputs.
  logic [31:0] m_reg [32];
  logic [31:0] m_pend;
  logic [31:0] m_val [2];
  logic [1:0]  m_busy;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_reg[r] = '0;
    m_pend = '0;
    m_val[0] = '0;
    m_val[1] = '0;
    m_busy = '0;
  endtask

  task automatic idle();
    rd_stb = 0; rs_en = 0; rs_addr = 0; wb_en = 0; wb_addr = 0; wb_sel = 0;
    alu_result = 0; load_result = 0; csr_val = 0; sb_set = 0; sb_addr = 0;
  endtask

  // One clock edge: the retiring write lands first (so reads see it), the
  // capture happens next, and a new issue is recorded last.
  task automatic cycle();
    logic [31:0] wdata;
    logic [4:0]  a;
    case (wb_sel)
      2'd1:    wdata = load_result;
      2'd2:    wdata = csr_val;
      default: wdata = alu_result;
    endcase
    if (wb_en && wb_addr != 0) begin
      m_reg[wb_addr]  = wdata;
      m_pend[wb_addr] = 1'b0;
    end
    if (rd_stb) begin
      for (int p = 0; p < 2; p++) begin
        a = rs_addr[p*5 +: 5];
        m_val[p]  = rs_en[p] ? m_reg[a]  : 32'd0;
        m_busy[p] = rs_en[p] ? m_pend[a] : 1'b0;
      end
    end
    if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
    @(posedge clk);
    #1;
    check("rs_val0",  rs_val[31:0],  m_val[0]);
    check("rs_val1",  rs_val[63:32], m_val[1]);
    check("rs_busy0", rs_busy[0],    m_busy[0]);
    check("rs_busy1", rs_busy[1],    m_busy[1]);
    check("pending",  pending,       m_pend);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [1:0] sel, input logic [31:0] d);
    idle();
    wb_en = 1; wb_addr = addr; wb_sel = sel;
    alu_result = d; load_result = d; csr_val = d;
    if (sel == 2'd1) alu_result = ~d;
    if (sel == 2'd2) load_result = ~d;
    cycle();
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    idle();
    rd_stb = 1; rs_en = 2'b11; rs_addr = {a1, a0};
    cycle();
  endtask

  initial begin
    idle();
    d2_rd_stb = 0; d2_rs_en = 0; d2_rs_addr = 0; d2_wb_en = 0; d2_wb_addr = 0;
    d2_wb_sel = 0; d2_alu = 0; d2_load = 0; d2_csr = 0; d2_sb_set = 0; d2_sb_addr = 0;
    model_reset();
    rst_n = 0;
    #1;
    check("reset_val",     rs_val,  64'd0);
    check("reset_pending", pending, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;

    // Basic write/read with x0 on port 1
    wr(5'd3, 2'd0, 32'h12345678);
    rd(5'd3, 5'd0);
    check("basic_p0", rs_val[31:0], 32'h12345678);
    check("basic_p1", rs_val[63:32], 32'd0);

    // Source select and dropped x0 write
    wr(5'd7, 2'd1, 32'hA5A5A5A5);
    wr(5'd8, 2'd2, 32'h00000C00);
    wr(5'd0, 2'd0, 32'hFFFFFFFF);
    rd(5'd7, 5'd8);
    check("load_src", rs_val[31:0], 32'hA5A5A5A5);
    check("csr_src",  rs_val[63:32], 32'h00000C00);
    rd(5'd0, 5'd0);
    check("x0_zero", rs_val, 64'd0);

    // Read hold with rd_stb low
    idle(); rs_en = 2'b11; rs_addr = {5'd3, 5'd3}; cycle();

    // Bypass on both ports
    wr(5'd9, 2'd0, 32'h11111111);
    idle(); rd_stb = 1; rs_en = 2'b11; rs_addr = {5'd9, 5'd9};
    wb_en = 1; wb_addr = 5'd9; alu_result = 32'h22222222; cycle();
    check("bypass_p0", rs_val[31:0],  32'h22222222);
    check("bypass_p1", rs_val[63:32], 32'h22222222);

    // Scoreboard hazard and retire-with-restrobe
    idle(); sb_set = 1; sb_addr = 5'd10; cycle();
    rd(5'd10, 5'd0);
    check("sb_busy", rs_busy[0], 1'b1);
    idle(); rd_stb = 1; rs_en = 2'b01; rs_addr = {5'd0, 5'd10};
    wb_en = 1; wb_addr = 5'd10; alu_result = 32'h55; cycle();
    check("sb_retire_val",  rs_val[31:0], 32'h55);
    check("sb_retire_busy", rs_busy[0], 1'b0);
    check("sb_retire_pend", pending[10], 1'b0);

    // Set and clear of x11 on one edge: set wins; x0 never pending
    idle(); sb_set = 1; sb_addr = 5'd11; wb_en = 1; wb_addr = 5'd11;
    alu_result = 32'h77; cycle();
    check("sb_set_wins", pending[11], 1'b1);
    idle(); sb_set = 1; sb_addr = 5'd0; cycle();
    check("sb_x0", pending[0], 1'b0);

    // Same-edge sb_set does not affect that capture
    idle(); rd_stb = 1; rs_en = 2'b01; rs_addr = {5'd0, 5'd12};
    sb_set = 1; sb_addr = 5'd12; cycle();
    check("sb_late_set", rs_busy[0], 1'b0);

    // Reset between edges with live state
    wr(5'd5, 2'd0, 32'hDEADBEEF);
    rd(5'd5, 5'd11);
    idle();
    #1 rst_n = 0;
    #1;
    check("midreset_val",  rs_val,  64'd0);
    check("midreset_busy", rs_busy, 2'd0);
    check("midreset_pend", pending, 32'd0);
    model_reset();
    #1 rst_n = 1;
    rd(5'd5, 5'd11);
    check("after_reset_x5", rs_val[31:0], 32'd0);

    // Random traffic on a small address window for frequent collisions
    for (int i = 0; i < 400; i++) begin
      rd_stb      = 1'($urandom_range(0, 1));
      rs_en       = 2'($urandom_range(0, 3));
      rs_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wb_en       = 1'($urandom_range(0, 1));
      wb_addr     = 5'($urandom_range(0, 7));
      wb_sel      = 2'($urandom_range(0, 3));
      alu_result  = $urandom;
      load_result = $urandom;
      csr_val     = $urandom;
      sb_set      = ($urandom_range(0, 3) == 0);
      sb_addr     = 5'($urandom_range(0, 7));
      cycle();
    end
    idle();

    // 64-bit / 16-register / 3-port instance: per-port slicing
    d2_wb_en = 1; d2_wb_addr = 4'd1; d2_wb_sel = 2'd0; d2_alu = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    d2_wb_addr = 4'd2; d2_wb_sel = 2'd1; d2_load = 64'hFEDCBA9876543210;
    @(posedge clk); #1;
    d2_wb_addr = 4'd15; d2_wb_sel = 2'd2; d2_csr = 64'hA5A55A5AC3C33C3C;
    @(posedge clk); #1;
    d2_wb_en = 0; d2_rd_stb = 1; d2_rs_en = 3'b111; d2_rs_addr = {4'd15, 4'd2, 4'd1};
    @(posedge clk); #1;
    check("p3_port0", d2_rs_val[63:0],    64'h0123456789ABCDEF);
    check("p3_port1", d2_rs_val[127:64],  64'hFEDCBA9876543210);
    check("p3_port2", d2_rs_val[191:128], 64'hA5A55A5AC3C33C3C);
    check("p3_busy",  d2_rs_busy, 3'd0);
    d2_rs_en = 3'b101; d2_rs_addr = {4'd1, 4'd15, 4'd2};
    @(posedge clk); #1;
    check("p3_perm0", d2_rs_val[63:0],    64'hFEDCBA9876543210);
    check("p3_perm1", d2_rs_val[127:64],  64'd0);
    check("p3_perm2", d2_rs_val[191:128], 64'h0123456789ABCDEF);
    check("p3_pend",  d2_pending, 16'd0);
    d2_rd_stb = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
